// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter. Bytes written to BASE_ADDR go through a
// small FIFO to the serialiser. Reading BASE_ADDR returns full/idle/overflow.
module csr_uart_tx #(
    parameter logic [11:0] BASE_ADDR = 12'hBC0,
    parameter int unsigned DIVISOR   = 16,
    parameter int unsigned FIFO_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        tx,
    output logic        AVOID_WARNING
);

    localparam int unsigned DEPTH       = 1 << FIFO_LOG2;
    localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic               r_hit, r_rd, r_ovf;
    logic [FIFO_LOG2:0] r_wptr, r_rptr;
    logic [7:0]         r_mem [DEPTH];
    state_t             r_state, w_state_n;
    logic [15:0]        r_baud, w_baud_n;
    logic [7:0]         r_shift, w_shift_n;
    logic [2:0]         r_bit, w_bit_n;
    logic               r_tx, w_tx_n;

    logic        w_full, w_empty, w_push_req, w_push, w_pop, w_bit_end;
    logic [7:0]  w_head;
    logic [31:0] w_status;
    logic        w_unused_wdata;

    assign w_full     = (r_wptr ^ r_rptr) == {1'b1, {FIFO_LOG2{1'b0}}};
    assign w_empty    = r_wptr == r_rptr;
    assign w_head     = r_mem[r_rptr[FIFO_LOG2-1:0]];
    assign w_push_req = r_hit && (modify == 3'd1);
    // A full FIFO still takes the byte when the serialiser frees a slot this cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_bit_end  = r_baud == 16'd0;

    assign w_status = {21'd0, r_ovf, w_empty && (r_state == S_IDLE), w_full, 8'd0};
    assign valid    = r_rd;
    assign rdata    = r_rd ? w_status : 32'd0;
    assign tx       = r_tx;

    assign AVOID_WARNING  = 1'b0;
    assign w_unused_wdata = ^wdata[31:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit <= 1'b0;
            r_rd  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_hit <= addr == BASE_ADDR;
            r_rd  <= read && (addr == BASE_ADDR);
            if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            else if (r_rd)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[FIFO_LOG2-1:0]] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_shift <= 8'd0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_shift <= w_shift_n;
            r_bit   <= w_bit_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = w_bit_end ? BAUD_RELOAD : r_baud - 16'd1;
        w_shift_n = r_shift;
        w_bit_n   = r_bit;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_n   = 1'b1;
                w_baud_n = 16'd0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_tx_n    = 1'b0;
                    w_baud_n  = BAUD_RELOAD;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_n    = r_shift[0];
                    w_bit_n   = 3'd0;
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_state_n = S_STOP;
                    end else begin
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                        w_bit_n   = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit so frames go back to back.
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_tx_n    = 1'b0;
                        w_state_n = S_START;
                    end else begin
                        w_tx_n    = 1'b1;
                        w_baud_n  = 16'd0;
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_n    = 1'b1;
                w_baud_n  = 16'd0;
                w_state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_uart_tx.sv
// Directed bench for csr_uart_tx: frame table, back-to-back frames, overflow,
// address/modify filtering and mid-frame reset, with a UART receiver monitor.
module tb_csr_uart_tx;
    localparam int          DIV  = 4;
    localparam logic [11:0] BASE = 12'hBC0;

    logic        clk = 1'b0, rst = 1'b1, read = 1'b0;
    logic [2:0]  modify = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [11:0] addr = 12'd0;
    logic [31:0] rdata;
    logic        valid, tx, aw;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    csr_uart_tx #(.BASE_ADDR(BASE), .DIVISOR(DIV), .FIFO_LOG2(3)) dut (
        .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata),
        .addr(addr), .rdata(rdata), .valid(valid), .tx(tx), .AVOID_WARNING(aw)
    );

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  frame;   // level of each bit slot, start bit in [0]
        logic [31:0] status;
    } vec_t;
    vec_t vecs[4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic csr_read(output logic v, output logic [31:0] d);
        read = 1'b1; addr = BASE;
        tick;
        read = 1'b0; addr = 12'd0;
        v = valid; d = rdata;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [2:0] m, input logic [7:0] b);
        addr = a;
        tick;
        addr = 12'd0; modify = m; wdata = {24'hA5A5A5, b};
        tick;
        modify = 3'd0; wdata = 32'd0;
    endtask

    task automatic capture(input int n, output logic [79:0] obs);
        obs = '0;
        for (int j = 0; j < n; j++) begin
            obs[j] = tx;
            tick;
        end
    endtask

    function automatic logic [39:0] expand(input logic [9:0] f);
        logic [39:0] r;
        for (int j = 0; j < 40; j++) r[j] = f[j / DIV];
        return r;
    endfunction

    // Receiver: samples each bit mid-slot after detecting a start bit.
    logic [7:0] rx_q[$];
    int frame_err = 0;
    initial begin : mon
        logic [9:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                b = '0;
                repeat (DIV / 2) @(negedge clk);
                b[0] = tx;
                for (int k = 1; k <= 9; k++) begin
                    repeat (DIV) @(negedge clk);
                    b[k] = tx;
                end
                rx_q.push_back(b[8:1]);
                if (b[0] !== 1'b0 || b[9] !== 1'b1) frame_err++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        v;
        logic [31:0] d;
        logic [79:0] obs;
        int          waited;

        vecs[0] = '{8'h55, 10'h2AA, 32'h200};
        vecs[1] = '{8'h00, 10'h200, 32'h200};
        vecs[2] = '{8'hFF, 10'h3FE, 32'h200};
        vecs[3] = '{8'hA5, 10'h34A, 32'h200};

        // reset, then first status read
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("reset_tx", tx, 1'b1);
        chk("reset_valid", valid, 1'b0);
        chk("reset_rdata", rdata, 32'd0);
        chk("aw_zero", aw, 1'b0);
        read = 1'b1; addr = BASE;
        #1 chk("valid_not_same_cycle", valid, 1'b0);
        tick;
        read = 1'b0; addr = 12'd0;
        chk("read_valid", valid, 1'b1);
        chk("read_status", rdata, 32'h200);
        tick;
        chk("valid_one_cycle", valid, 1'b0);
        chk("rdata_deselected", rdata, 32'd0);

        // single frames from the table
        foreach (vecs[i]) begin
            csr_write(BASE, 3'd1, vecs[i].data);
            chk($sformatf("tx_high_write_edge_%0d", i), tx, 1'b1);
            tick;
            capture(40, obs);
            chk($sformatf("frame_%0d", i), obs, {40'd0, expand(vecs[i].frame)});
            csr_read(v, d);
            chk($sformatf("frame_valid_%0d", i), v, 1'b1);
            chk($sformatf("frame_status_%0d", i), d, vecs[i].status);
        end

        // back-to-back frames
        addr = BASE;
        tick;
        modify = 3'd1; wdata = 32'h41;
        tick;
        wdata = 32'h42; addr = 12'd0;
        tick;
        modify = 3'd0; wdata = 32'd0;
        capture(80, obs);
        chk("back_to_back", obs, {expand(10'h284), expand(10'h282)});
        csr_read(v, d);
        chk("b2b_status", d, 32'h200);

        // overflow: ten writes into an eight-deep FIFO
        rx_q.delete();
        frame_err = 0;
        addr = BASE;
        tick;
        for (int b = 1; b <= 10; b++) begin
            modify = 3'd1; wdata = 32'(b);
            tick;
        end
        modify = 3'd0; wdata = 32'd0; read = 1'b1;
        tick;
        chk("ovf_status", rdata, 32'h500);
        tick;
        chk("ovf_cleared", rdata, 32'h100);
        read = 1'b0; addr = 12'd0;
        waited = 0;
        while (rx_q.size() < 9 && waited < 600) begin
            tick;
            waited++;
        end
        repeat (60) tick;
        chk("ovf_rx_count", rx_q.size(), 9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            chk($sformatf("ovf_rx_byte_%0d", i), rx_q[i], 8'(i + 1));
        chk("ovf_framing", frame_err, 0);
        csr_read(v, d);
        chk("ovf_final_status", d, 32'h200);

        // wrong address and non-write modify
        read = 1'b1; addr = 12'hBC1;
        tick;
        read = 1'b0; addr = 12'd0;
        chk("bad_addr_valid", valid, 1'b0);
        chk("bad_addr_rdata", rdata, 32'd0);
        csr_write(12'hBC1, 3'd1, 8'h33);
        capture(12, obs);
        chk("bad_addr_no_push", obs, 80'hFFF);
        csr_write(BASE, 3'd2, 8'h33);
        capture(12, obs);
        chk("modify2_no_push", obs, 80'hFFF);
        csr_read(v, d);
        chk("filter_status", d, 32'h200);

        // reset during data bit 3 with a second byte queued
        addr = BASE;
        tick;
        modify = 3'd1; wdata = 32'h07;
        tick;
        wdata = 32'h77; addr = 12'd0;
        tick;
        modify = 3'd0; wdata = 32'd0;
        repeat (17) tick;
        chk("mid_bit3_level", tx, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_valid", valid, 1'b0);
        capture(60, obs);
        chk("rst_no_frames", obs, 80'hFFF_FFFF_FFFF_FFFF);
        csr_read(v, d);
        chk("rst_mid_status", d, 32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
